// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the register file's single read port among NREQ requesters.
// Two-stage pipeline: arbitrate/drive rf_sel, then capture rf_data tagged with the winner's ID.
module regfile_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 64,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        rf_sel,
    input  logic [DW-1:0]        rf_data,
    output logic                 rd_valid,
    output logic [IDW-1:0]       rd_id,
    output logic [DW-1:0]        rd_data,
    output logic                 busy
);

    generate
        if ((NREQ < 2) || (NREQ > 8) || (IDW != $clog2(NREQ))) begin : g_param_err
            $error("regfile_read_arbiter: NREQ must be 2..8 and IDW must equal clog2(NREQ)");
        end
    endgenerate

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    // Modulo-NREQ addition of requester indices
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input logic [IDW-1:0] off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NREQ_W) begin
            return IDW'(sum - NREQ_W);
        end else begin
            return sum[IDW-1:0];
        end
    endfunction

    logic [NREQ-1:0] gnt_q,      gnt_d;
    logic [AW-1:0]   rf_sel_q,   rf_sel_d;
    logic            a_valid_q,  a_valid_d;
    logic [IDW-1:0]  a_id_q,     a_id_d;
    logic [IDW-1:0]  ptr_q,      ptr_d;
    logic            rd_valid_q, rd_valid_d;
    logic [IDW-1:0]  rd_id_q,    rd_id_d;
    logic [DW-1:0]   rd_data_q,  rd_data_d;

    logic            found_s;
    logic [IDW-1:0]  win_s;
    logic [IDW-1:0]  cand_s;
    logic [AW-1:0]   sel_s;

    // Round-robin search: first requesting index at or above the pointer, wrapping
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = wrap_add(ptr_q, IDW'(k));
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Address slice of the winning requester
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_s == IDW'(i)) begin
                sel_s = addr[i*AW +: AW];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Next-state for the arbitrate and capture stages
    always_comb begin
        gnt_d      = '0;
        rf_sel_d   = rf_sel_q;
        a_valid_d  = 1'b0;
        a_id_d     = a_id_q;
        ptr_d      = ptr_q;
        rd_valid_d = a_valid_q;
        rd_id_d    = rd_id_q;
        rd_data_d  = rd_data_q;
        if (found_s) begin
            gnt_d     = NREQ'(1'b1) << win_s;
            rf_sel_d  = sel_s;
            a_valid_d = 1'b1;
            a_id_d    = win_s;
            ptr_d     = wrap_add(win_s, IDW'(1'b1));
        end else begin
            gnt_d     = '0;
            a_valid_d = 1'b0;
        end
        // rf_data is the mux output for the rf_sel registered one edge earlier
        if (a_valid_q) begin
            rd_data_d = rf_data;
            rd_id_d   = a_id_q;
        end else begin
            rd_data_d = rd_data_q;
            rd_id_d   = rd_id_q;
        end
    end

    // Pipeline registers; reset discards any in-flight read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q      <= '0;
            rf_sel_q   <= '0;
            a_valid_q  <= 1'b0;
            a_id_q     <= '0;
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            gnt_q      <= gnt_d;
            rf_sel_q   <= rf_sel_d;
            a_valid_q  <= a_valid_d;
            a_id_q     <= a_id_d;
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign gnt      = gnt_q;
    assign rf_sel   = rf_sel_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_data  = rd_data_q;
    assign busy     = (|gnt_q) | a_valid_q | rd_valid_q;

endmodule
